// File: rtl/conv2_pool_flatten.sv
// conv2_pool_flatten: 2x2 max-pool + ReLU + 8-bit requantize of the 3-channel conv2 map,
// buffered in a feature memory and streamed to FC1 in flattened channel-major order.
module conv2_pool_flatten #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAP_W     = 8,
    parameter int unsigned MAP_H     = 8,
    parameter int unsigned OUT_SHIFT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_ch0,
    input  logic [DATA_W-1:0] i_ch1,
    input  logic [DATA_W-1:0] i_ch2,
    output logic [7:0]        o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int unsigned PW     = MAP_W / 2;
    localparam int unsigned PH     = MAP_H / 2;
    localparam int unsigned NP     = PW * PH;
    localparam int unsigned NF     = 3 * NP;
    localparam int unsigned COL_W  = $clog2(MAP_W);
    localparam int unsigned ROW_W  = $clog2(MAP_H);
    localparam int unsigned PCOL_W = COL_W - 1;
    localparam int unsigned PROW_W = ROW_W - 1;
    localparam int unsigned IDX_W  = $clog2(NF);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NF - 1);
    localparam logic signed [DATA_W-1:0] QMAX = DATA_W'(127);

    typedef enum logic [0:0] {StCollect, StDrain} state_e;

    state_e             state_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [IDX_W-1:0]   rd_nxt;
    logic [PCOL_W-1:0]  pcol;
    logic [PROW_W-1:0]  prow;
    logic               accept;

    logic signed [DATA_W-1:0] in_s     [3];
    logic signed [DATA_W-1:0] tmp_q    [3];
    logic signed [DATA_W-1:0] line_q   [3][PW];
    logic signed [DATA_W-1:0] pair_max [3];
    logic signed [DATA_W-1:0] pool_max [3];
    logic [7:0]               q_val    [3];
    logic [IDX_W-1:0]         widx     [3];
    logic [7:0]               fmem_q   [NF];

    // ReLU, then arithmetic shift and saturate to 0..127; only this step narrows.
    function automatic logic [7:0] quant(input logic signed [DATA_W-1:0] p);
        logic signed [DATA_W-1:0] s;
        if (p[DATA_W-1] || (p == '0)) return 8'd0;
        s = p >>> OUT_SHIFT;
        if (s > QMAX) return 8'd127;
        return s[7:0];
    endfunction

    // Pooling datapath: pair max, block max, quantized value and feature address.
    always_comb begin
        in_s[0] = $signed(i_ch0);
        in_s[1] = $signed(i_ch1);
        in_s[2] = $signed(i_ch2);
        pcol    = col_q[COL_W-1:1];
        prow    = row_q[ROW_W-1:1];
        accept  = i_valid && (state_q == StCollect);
        rd_nxt  = rd_idx_q + 1'b1;
        for (int c = 0; c < 3; c++) begin
            pair_max[c] = (in_s[c] > tmp_q[c]) ? in_s[c] : tmp_q[c];
            pool_max[c] = (line_q[c][pcol] > pair_max[c]) ? line_q[c][pcol] : pair_max[c];
            q_val[c]    = quant(pool_max[c]);
            widx[c]     = IDX_W'(c * NP + int'(prow) * PW + int'(pcol));
        end
    end

    // Pool state and feature memory; every entry is rewritten each frame, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                if (!col_q[0]) begin
                    tmp_q[c] <= in_s[c];
                end else if (!row_q[0]) begin
                    line_q[c][pcol] <= pair_max[c];
                end else begin
                    fmem_q[widx[c]] <= q_val[c];
                end
            end
        end
    end

    // Control FSM: raster counters while collecting, registered-read streaming while draining.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StCollect;
            col_q     <= '0;
            row_q     <= '0;
            rd_idx_q  <= '0;
            o_data    <= 8'd0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state_q)
                StCollect: begin
                    if (i_valid) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q    <= '0;
                                rd_idx_q <= '0;
                                o_busy   <= 1'b1;
                                state_q  <= StDrain;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Inputs are never accepted here, including on the final transfer.
                    if (i_valid) o_overrun <= 1'b1;
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_data  <= fmem_q[rd_idx_q];
                        o_last  <= (rd_idx_q == IDX_LAST);
                    end else if (i_ready) begin
                        if (o_last) begin
                            o_valid  <= 1'b0;
                            o_last   <= 1'b0;
                            o_done   <= 1'b1;
                            o_busy   <= 1'b0;
                            rd_idx_q <= '0;
                            state_q  <= StCollect;
                        end else begin
                            rd_idx_q <= rd_nxt;
                            o_data   <= fmem_q[rd_nxt];
                            o_last   <= (rd_nxt == IDX_LAST);
                        end
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_pool_flatten.sv
// Directed bench for conv2_pool_flatten: two instances (OUT_SHIFT 0 and 4) share stimulus.
module tb_conv2_pool_flatten;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, ready;
    logic [15:0] ch0, ch1, ch2;
    logic [7:0]  d0, d4;
    logic        v0, v4, l0, l4, dn0, dn4, b0, b4, ov0, ov4;

    conv2_pool_flatten #(.DATA_W(16), .MAP_W(8), .MAP_H(8), .OUT_SHIFT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_ch0(ch0), .i_ch1(ch1), .i_ch2(ch2),
        .o_data(d0), .o_valid(v0), .i_ready(ready), .o_last(l0), .o_done(dn0), .o_busy(b0),
        .o_overrun(ov0)
    );

    conv2_pool_flatten #(.DATA_W(16), .MAP_W(8), .MAP_H(8), .OUT_SHIFT(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_ch0(ch0), .i_ch1(ch1), .i_ch2(ch2),
        .o_data(d4), .o_valid(v4), .i_ready(ready), .o_last(l4), .o_done(dn4), .o_busy(b4),
        .o_overrun(ov4)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] img0 [64];
    logic [15:0] img1 [64];
    logic [15:0] img2 [64];
    logic [7:0]  exp0 [48];
    logic [7:0]  exp4 [48];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ramp frame: ch0 = row*8+col, ch1 = -ch0, ch2 = 0; pooled ch0 = (2pr+1)*8 + 2pc+1.
    task automatic load_ramp();
        int v;
        for (int i = 0; i < 64; i++) begin
            img0[i] = 16'(i);
            img1[i] = 16'(-i);
            img2[i] = 16'd0;
        end
        for (int p = 0; p < 48; p++) begin
            exp0[p] = 8'd0;
            exp4[p] = 8'd0;
        end
        for (int p = 0; p < 16; p++) begin
            v       = (2 * (p / 4) + 1) * 8 + 2 * (p % 4) + 1;
            exp0[p] = 8'(v);
            exp4[p] = 8'(v / 16);
        end
    endtask

    task automatic set_block(input int ch, input int pos, input int a, input int b,
                             input int c, input int d, input int e0, input int e4);
        int base;
        base = (2 * (pos / 4)) * 8 + 2 * (pos % 4);
        if (ch == 0) begin
            img0[base] = 16'(a); img0[base+1] = 16'(b); img0[base+8] = 16'(c); img0[base+9] = 16'(d);
        end else if (ch == 1) begin
            img1[base] = 16'(a); img1[base+1] = 16'(b); img1[base+8] = 16'(c); img1[base+9] = 16'(d);
        end else begin
            img2[base] = 16'(a); img2[base+1] = 16'(b); img2[base+8] = 16'(c); img2[base+9] = 16'(d);
        end
        exp0[ch*16 + pos] = 8'(e0);
        exp4[ch*16 + pos] = 8'(e4);
    endtask

    // Saturation / ReLU frame; expected values worked out by hand for shifts 0 and 4.
    task automatic load_sat();
        for (int i = 0; i < 64; i++) begin
            img0[i] = 16'd0; img1[i] = 16'd0; img2[i] = 16'd0;
        end
        for (int p = 0; p < 48; p++) begin
            exp0[p] = 8'd0; exp4[p] = 8'd0;
        end
        set_block(0, 0, 32767, 3, -1, 0, 127, 127);
        set_block(0, 1, -5, -7, -9, -6, 0, 0);
        set_block(0, 2, 2047, 0, 5, 2046, 127, 127);
        set_block(0, 3, 1, 2032, -3, 2000, 127, 127);
        set_block(0, 4, 2031, 2031, 2030, 0, 127, 126);
        set_block(0, 5, 16, -16, 0, 3, 16, 1);
        set_block(0, 6, 15, 0, 0, 0, 15, 0);
        set_block(0, 7, -32768, -32768, -32768, -32768, 0, 0);
        set_block(1, 0, -32768, -1, -100, -2, 0, 0);
        set_block(1, 1, 100, 99, -100, 50, 100, 6);
        set_block(1, 9, 0, 0, 0, 127, 127, 7);
        set_block(2, 0, 0, 0, 0, 32767, 127, 127);
        set_block(2, 14, 128, 0, 0, 0, 127, 8);
        set_block(2, 15, -1, 300, 0, 0, 127, 18);
    endtask

    task automatic send_frame(input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            ch0 = img0[i]; ch1 = img1[i]; ch2 = img2[i];
            step();
            in_valid = 1'b0;
            if (gap != 0 && (i % gap) == gap - 1) step();
        end
    endtask

    // mode 1: ready pattern 1,0,0,1; ovr != 0: pulse i_valid twice mid-drain.
    task automatic drain(input int mode, input int ovr, input string tag);
        int         n         = 0;
        int         cyc       = 0;
        int         early_dn  = 0;
        logic       stall     = 1'b0;
        logic [7:0] held0     = 8'd0;
        logic [7:0] held4     = 8'd0;
        logic       rdy;
        while (n < 48 && cyc < 600) begin
            if (dn0) early_dn++;
            if (stall) begin
                chk({tag, " hold valid"}, 32'(v0), 1);
                chk({tag, " hold d0"}, 32'(d0), 32'(held0));
                chk({tag, " hold d4"}, 32'(d4), 32'(held4));
            end
            rdy      = (mode == 1) ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            ready    = rdy;
            in_valid = (ovr != 0) && (cyc == 5 || cyc == 20);
            ch0 = 16'h1234; ch1 = 16'h0777; ch2 = 16'h7fff;
            if (v0) chk({tag, " busy"}, 32'(b0), 1);
            if (v0 && rdy) begin
                chk($sformatf("%s word%0d d0", tag, n), 32'(d0), 32'(exp0[n]));
                chk($sformatf("%s word%0d d4", tag, n), 32'(d4), 32'(exp4[n]));
                chk($sformatf("%s word%0d last", tag, n), 32'(l0), 32'(n == 47));
                chk($sformatf("%s word%0d v4", tag, n), 32'(v4), 1);
                n++;
            end
            stall = v0 && !rdy;
            held0 = d0;
            held4 = d4;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        ready    = 1'b1;
        chk({tag, " word count"}, 32'(n), 48);
        chk({tag, " early done"}, 32'(early_dn), 0);
        chk({tag, " done pulse"}, 32'(dn0), 1);
        chk({tag, " done pulse4"}, 32'(dn4), 1);
        chk({tag, " valid drop"}, 32'(v0), 0);
        chk({tag, " busy drop"}, 32'(b0), 0);
        step();
        chk({tag, " done clear"}, 32'(dn0), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ready = 1'b1;
        ch0 = 16'd0; ch1 = 16'd0; ch2 = 16'd0;
        step();
        step();
        chk("reset data", 32'(d0), 0);
        chk("reset valid", 32'(v0), 0);
        chk("reset last", 32'(l0), 0);
        chk("reset done", 32'(dn0), 0);
        chk("reset busy", 32'(b0), 0);
        chk("reset overrun", 32'(ov0), 0);
        rst = 1'b0;
        step();

        load_ramp();
        send_frame(0, 64);
        drain(0, 0, "s1");

        load_sat();
        send_frame(0, 64);
        drain(0, 0, "s2");

        load_ramp();
        send_frame(5, 64);
        drain(1, 0, "s3");
        chk("overrun clean", 32'(ov0), 0);

        load_ramp();
        send_frame(0, 64);
        drain(0, 1, "s4");
        chk("overrun set", 32'(ov0), 1);
        chk("overrun set4", 32'(ov4), 1);
        send_frame(0, 64);
        drain(0, 0, "s4b");
        chk("overrun sticky", 32'(ov0), 1);

        load_sat();
        send_frame(0, 30);
        rst = 1'b1;
        step();
        chk("s5 reset valid", 32'(v0), 0);
        chk("s5 reset busy", 32'(b0), 0);
        step();
        chk("s5 reset valid2", 32'(v0), 0);
        chk("s5 overrun clear", 32'(ov0), 0);
        rst = 1'b0;
        step();
        load_ramp();
        send_frame(0, 64);
        drain(0, 0, "s5");

        load_ramp();
        send_frame(3, 64);
        drain(0, 0, "s6a");
        load_sat();
        send_frame(2, 64);
        drain(1, 0, "s6b");
        chk("s6 overrun", 32'(ov0), 0);
        chk("s6 overrun4", 32'(ov4), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
